// File: rtl/spi_pkg.sv
// Shared definitions for the register-SPI blocks: frame geometry, register map
// and the controller state encoding.
package spi_pkg;

  localparam int FRAME_W = 16;
  localparam int ADDR_W  = 7;
  localparam int DATA_W  = 8;

  localparam logic [ADDR_W-1:0] REG_EN_OUT_7_0  = 7'h00;
  localparam logic [ADDR_W-1:0] REG_EN_OUT_15_8 = 7'h01;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_7_0  = 7'h02;
  localparam logic [ADDR_W-1:0] REG_EN_PWM_15_8 = 7'h03;
  localparam logic [ADDR_W-1:0] REG_PWM_DUTY    = 7'h04;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    HOLD,
    GAP
  } state_t;

  typedef logic [FRAME_W-1:0] frame_t;

  // Frame layout on the wire: {rw, addr, data}, sent MSB first.
  function automatic frame_t pack_frame(input logic rw,
                                        input logic [ADDR_W-1:0] addr,
                                        input logic [DATA_W-1:0] data);
    return {rw, addr, data};
  endfunction

endpackage

// File: rtl/spi_reg_controller_if.sv
// Command handshake plus SPI pin bundle between a command source (master)
// and the SPI controller (slave).
interface spi_reg_controller_if;
  import spi_pkg::*;

  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_rw;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_data;
  logic              sclk;
  logic              mosi;
  logic              cs_n;
  logic              busy;
  logic              done;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_data,
    input  cmd_ready, sclk, mosi, cs_n, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_data,
    output cmd_ready, sclk, mosi, cs_n, busy, done
  );

endinterface

// File: rtl/spi_clk_div.sv
// Half-period counter: counts 0..DIV-1 while enabled and flags the terminal
// count so the owner can toggle its clock phase.
module spi_clk_div #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = en_i && (cnt_q == CW'(DIV - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i || tick_o) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_reg_controller.sv
// Write-only SPI initiator: serialises one 16-bit register command per frame,
// mode 0, MSB first, with chip-select lead/lag and a minimum deselect gap.
module spi_reg_controller
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_reg_controller_if.slave  bus
);

  state_t             state_q;
  logic [FRAME_W-2:0] shift_q;
  logic [3:0]         bit_q;
  logic               sclk_q;
  logic               mosi_q;
  logic               cs_n_q;
  logic               busy_q;
  logic               done_q;
  logic               ready_q;
  logic               tick;
  frame_t             cmd_frame;

  assign cmd_frame = pack_frame(bus.cmd_rw, bus.cmd_addr, bus.cmd_data);

  // The divider runs only while a frame is in flight and restarts at zero
  // for every frame, so each phase lasts exactly CLK_DIV cycles.
  spi_clk_div #(
    .DIV(CLK_DIV)
  ) u_clk_div (
    .clk   (clk),
    .rst   (rst),
    .en_i  (state_q != IDLE),
    .clr_i (state_q == IDLE),
    .tick_o(tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      shift_q <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus.cmd_valid) begin
            state_q <= SHIFT;
            mosi_q  <= cmd_frame[FRAME_W-1];
            shift_q <= cmd_frame[FRAME_W-2:0];
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            cs_n_q  <= 1'b0;
            busy_q  <= 1'b1;
            ready_q <= 1'b0;
          end
        end
        SHIFT: begin
          if (tick) begin
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Falling edge: present the next bit, or park mosi after bit 15.
              sclk_q <= 1'b0;
              if (bit_q == 4'd15) begin
                state_q <= HOLD;
                bit_q   <= '0;
                mosi_q  <= 1'b0;
              end else begin
                bit_q   <= bit_q + 4'd1;
                mosi_q  <= shift_q[FRAME_W-2];
                shift_q <= {shift_q[FRAME_W-3:0], 1'b0};
              end
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_q <= GAP;
            cs_n_q  <= 1'b1;
          end
        end
        GAP: begin
          if (tick) begin
            state_q <= IDLE;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
          cs_n_q  <= 1'b1;
          sclk_q  <= 1'b0;
          mosi_q  <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign bus.cmd_ready = ready_q;
  assign bus.sclk      = sclk_q;
  assign bus.mosi      = mosi_q;
  assign bus.cs_n      = cs_n_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
